game_screen_sequencer: RTL and testbench

//  Top-level screen controller for the 96x64 RGB565 OLED. Decodes the driver's pixel_index into x/y
//  for the screen modules and selects which screen drives oled_data: TITLE, MIC_TEST, PLAY, GAME_OVER.

---
 rtl/game_screen_sequencer_pkg.sv | 40 ++++
 rtl/game_screen_sequencer_pixel_xy_decode.sv | 24 ++
 rtl/game_screen_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_game_screen_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_screen_sequencer_pkg.sv
// Shared constants, screen identifiers and the colour-select helper used by the
// 96x64 OLED screen sequencer.
package game_screen_sequencer_pkg;

    localparam int OLED_W      = 96;
    localparam int OLED_H      = 64;
    localparam int OLED_PIXELS = OLED_W * OLED_H;

    typedef enum logic [1:0] {
        SCR_TITLE = 2'd0,
        SCR_MIC   = 2'd1,
        SCR_PLAY  = 2'd2,
        SCR_OVER  = 2'd3
    } screen_t;

    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;

    function automatic logic [15:0] screen_colour(
        input screen_t     sel,
        input logic [15:0] title_c,
        input logic [15:0] mic_c,
        input logic [15:0] play_c,
        input logic [15:0] over_c
    );
        logic [15:0] c;
        case (sel)
            SCR_TITLE: c = title_c;
            SCR_MIC:   c = mic_c;
            SCR_PLAY:  c = play_c;
            SCR_OVER:  c = over_c;
            default:   c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_screen_sequencer_pixel_xy_decode.sv
// Splits the driver's row-major pixel_index into x/y; out-of-range indices
// decode to the origin with in_range low.
module pixel_xy_decode
    import game_screen_sequencer_pkg::*;
(
    input  logic [12:0] pixel_index,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic        in_range
);

    // Pure combinational decode, 96 pixels per row.
    always_comb begin
        in_range = (pixel_index < 13'd6144);
        if (in_range) begin
            x = 7'(pixel_index % 13'd96);
            y = 6'(pixel_index / 13'd96);
        end else begin
            x = 7'd0;
            y = 6'd0;
        end
    end

endmodule

// File: rtl/game_screen_sequencer.sv
// Screen controller for the 96x64 OLED: picks the active screen, commits changes
// on frame boundaries and wipes left-to-right from the old screen to the new one.
module game_screen_sequencer
    import game_screen_sequencer_pkg::*;
#(
    parameter int PLAY_FRAMES     = 1800,
    parameter int MIC_THRESH      = 2048,
    parameter int MIC_HOLD_FRAMES = 30,
    parameter int WIPE_STEP       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic        btn_pulse,
    input  logic [11:0] mic_level,
    input  logic        game_lost,
    input  logic [15:0] scr_title_data,
    input  logic [15:0] scr_mic_data,
    input  logic [15:0] scr_play_data,
    input  logic [15:0] scr_over_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic [15:0] oled_data,
    output logic [1:0]  screen_id,
    output logic        wipe_active,
    output logic [10:0] play_frames_left
);

    localparam logic [10:0] PLAY_LOAD = PLAY_FRAMES[10:0];
    localparam logic [11:0] THRESH    = MIC_THRESH[11:0];
    localparam logic [5:0]  HOLD_MAX  = MIC_HOLD_FRAMES[5:0];
    localparam logic [6:0]  STEP      = WIPE_STEP[6:0];

    screen_t     screen_r;
    screen_t     prev_r;
    screen_t     target_r;
    logic        pending_r;
    logic        wipe_active_r;
    logic [6:0]  wipe_col_r;
    logic [10:0] play_left_r;
    logic [5:0]  mic_hold_r;
    logic [15:0] oled_r;

    logic        in_range_s;
    logic        req_valid_s;
    screen_t     req_target_s;
    logic        accept_s;
    logic        commit_s;
    logic [7:0]  wipe_sum_s;
    screen_t     pix_sel_s;
    logic [15:0] pix_colour_s;

    pixel_xy_decode u_xy (
        .pixel_index (pixel_index),
        .x           (x),
        .y           (y),
        .in_range    (in_range_s)
    );

    // Transition request for the current screen; within a screen the listed
    // sources share a target, so ordering only documents priority.
    always_comb begin
        req_valid_s  = 1'b0;
        req_target_s = screen_r;
        case (screen_r)
            SCR_TITLE: begin
                if (btn_pulse) begin
                    req_valid_s  = 1'b1;
                    req_target_s = SCR_MIC;
                end else begin
                    req_valid_s  = 1'b0;
                end
            end
            SCR_MIC: begin
                if ((mic_hold_r == HOLD_MAX) || btn_pulse) begin
                    req_valid_s  = 1'b1;
                    req_target_s = SCR_PLAY;
                end else begin
                    req_valid_s  = 1'b0;
                end
            end
            SCR_PLAY: begin
                if (game_lost || (play_left_r == 11'd0)) begin
                    req_valid_s  = 1'b1;
                    req_target_s = SCR_OVER;
                end else begin
                    req_valid_s  = 1'b0;
                end
            end
            SCR_OVER: begin
                if (btn_pulse) begin
                    req_valid_s  = 1'b1;
                    req_target_s = SCR_TITLE;
                end else begin
                    req_valid_s  = 1'b0;
                end
            end
            default: begin
                req_valid_s  = 1'b0;
                req_target_s = SCR_TITLE;
            end
        endcase
    end

    // Requests are dropped, not queued, while a wipe runs or one is already held.
    assign accept_s   = req_valid_s && !wipe_active_r && !pending_r;
    assign commit_s   = frame_begin && pending_r;
    assign wipe_sum_s = {1'b0, wipe_col_r} + {1'b0, STEP};

    // Screen state, pending request and wipe progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            screen_r      <= SCR_TITLE;
            prev_r        <= SCR_TITLE;
            target_r      <= SCR_TITLE;
            pending_r     <= 1'b0;
            wipe_active_r <= 1'b0;
            wipe_col_r    <= 7'd0;
        end else if (commit_s) begin
            prev_r        <= screen_r;
            screen_r      <= target_r;
            pending_r     <= 1'b0;
            wipe_active_r <= 1'b1;
            wipe_col_r    <= STEP;
        end else begin
            if (frame_begin && wipe_active_r) begin
                if (wipe_sum_s >= 8'd96) begin
                    wipe_active_r <= 1'b0;
                end else begin
                    wipe_col_r <= wipe_sum_s[6:0];
                end
            end
            if (accept_s) begin
                pending_r <= 1'b1;
                target_r  <= req_target_s;
            end
        end
    end

    // PLAY countdown and MIC_TEST loudness hold counter, both frame-paced.
    always_ff @(posedge clk) begin
        if (reset) begin
            play_left_r <= 11'd0;
            mic_hold_r  <= 6'd0;
        end else begin
            if (commit_s && (target_r == SCR_PLAY)) begin
                play_left_r <= PLAY_LOAD;
            end else if (frame_begin && (screen_r == SCR_PLAY) && (play_left_r != 11'd0)) begin
                play_left_r <= play_left_r - 11'd1;
            end else begin
                play_left_r <= play_left_r;
            end

            if (commit_s) begin
                mic_hold_r <= 6'd0;
            end else if (frame_begin && (screen_r == SCR_MIC)) begin
                if (mic_level >= THRESH) begin
                    if (mic_hold_r != HOLD_MAX) begin
                        mic_hold_r <= mic_hold_r + 6'd1;
                    end else begin
                        mic_hold_r <= mic_hold_r;
                    end
                end else begin
                    mic_hold_r <= 6'd0;
                end
            end else begin
                mic_hold_r <= mic_hold_r;
            end
        end
    end

    // Columns right of the wipe front still show the outgoing screen.
    always_comb begin
        if (wipe_active_r && (x >= wipe_col_r)) begin
            pix_sel_s = prev_r;
        end else begin
            pix_sel_s = screen_r;
        end
        pix_colour_s = screen_colour(pix_sel_s, scr_title_data, scr_mic_data,
                                     scr_play_data, scr_over_data);
    end

    // One-cycle registered pixel output; off-screen indices go black.
    always_ff @(posedge clk) begin
        if (reset) begin
            oled_r <= BLACK;
        end else if (in_range_s) begin
            oled_r <= pix_colour_s;
        end else begin
            oled_r <= BLACK;
        end
    end

    assign oled_data        = oled_r;
    assign screen_id        = screen_r;
    assign wipe_active      = wipe_active_r;
    assign play_frames_left = play_left_r;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Directed bench for game_screen_sequencer: a slow-wipe instance for wipe, mic
// hold and timeout behaviour, and a one-frame-wipe instance for game_lost.
module tb_game_screen_sequencer;

    localparam logic [15:0] C_T = 16'h1111;
    localparam logic [15:0] C_M = 16'h2222;
    localparam logic [15:0] C_P = 16'h3333;
    localparam logic [15:0] C_O = 16'h4444;

    logic        clk = 1'b0;
    logic        reset;
    logic        fb_m, fb_f, btn_m, btn_f, lost_m, lost_f;
    logic [12:0] pix;
    logic [11:0] mic, mic_f;
    logic [6:0]  x_m, x_f;
    logic [5:0]  y_m, y_f;
    logic [15:0] oled_m, oled_f;
    logic [1:0]  scr_m, scr_f;
    logic        wipe_m, wipe_f;
    logic [10:0] left_m, left_f;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    game_screen_sequencer #(
        .PLAY_FRAMES(5), .MIC_THRESH(2048), .MIC_HOLD_FRAMES(30), .WIPE_STEP(8)
    ) dut (
        .clk(clk), .reset(reset), .frame_begin(fb_m), .pixel_index(pix),
        .btn_pulse(btn_m), .mic_level(mic), .game_lost(lost_m),
        .scr_title_data(C_T), .scr_mic_data(C_M), .scr_play_data(C_P), .scr_over_data(C_O),
        .x(x_m), .y(y_m), .oled_data(oled_m), .screen_id(scr_m),
        .wipe_active(wipe_m), .play_frames_left(left_m)
    );

    game_screen_sequencer #(
        .PLAY_FRAMES(5), .MIC_THRESH(2048), .MIC_HOLD_FRAMES(30), .WIPE_STEP(96)
    ) dut_fast (
        .clk(clk), .reset(reset), .frame_begin(fb_f), .pixel_index(pix),
        .btn_pulse(btn_f), .mic_level(mic_f), .game_lost(lost_f),
        .scr_title_data(C_T), .scr_mic_data(C_M), .scr_play_data(C_P), .scr_over_data(C_O),
        .x(x_f), .y(y_f), .oled_data(oled_f), .screen_id(scr_f),
        .wipe_active(wipe_f), .play_frames_left(left_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame_m(input int n);
        repeat (n) begin
            fb_m = 1'b1;
            @(negedge clk);
            fb_m = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic frame_f(input int n);
        repeat (n) begin
            fb_f = 1'b1;
            @(negedge clk);
            fb_f = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic press_m();
        btn_m = 1'b1;
        @(negedge clk);
        btn_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_f();
        btn_f = 1'b1;
        @(negedge clk);
        btn_f = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        fb_m = 1'b0; fb_f = 1'b0; btn_m = 1'b0; btn_f = 1'b0;
        lost_m = 1'b0; lost_f = 1'b0;
        pix = 13'd0; mic = 12'd0; mic_f = 12'd0;
        repeat (2) @(negedge clk);

        chk("reset_screen", 32'(scr_m), 32'd0);
        chk("reset_wipe", 32'(wipe_m), 32'd0);
        chk("reset_oled", 32'(oled_m), 32'd0);
        chk("reset_left", 32'(left_m), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // TITLE -> MIC_TEST on a mid-frame button, committed at the next frame
        press_m();
        chk("btn_waits_frame", 32'(scr_m), 32'd0);
        frame_m(1);
        chk("commit_mic", 32'(scr_m), 32'd1);
        chk("commit_wipe_on", 32'(wipe_m), 32'd1);
        pix = 13'd10;
        @(negedge clk);
        chk("f1_x10_prev", 32'(oled_m), 32'(C_T));
        frame_m(1);
        pix = 13'd20;
        @(negedge clk);
        chk("f2_x20_prev", 32'(oled_m), 32'(C_T));
        pix = 13'd10;
        @(negedge clk);
        chk("f2_x10_new", 32'(oled_m), 32'(C_M));

        // button during the wipe must be dropped
        press_m();
        frame_m(9);
        chk("wipe_f11_on", 32'(wipe_m), 32'd1);
        frame_m(1);
        chk("wipe_f12_off", 32'(wipe_m), 32'd0);
        frame_m(2);
        chk("btn_in_wipe_dropped", 32'(scr_m), 32'd1);

        // mic hold: 29 loud, one quiet, then 30 loud
        mic = 12'd2048;
        frame_m(29);
        chk("mic_29_loud", 32'(scr_m), 32'd1);
        mic = 12'd2047;
        frame_m(1);
        mic = 12'd2048;
        frame_m(30);
        chk("mic_30_pending", 32'(scr_m), 32'd1);
        frame_m(1);
        mic = 12'd0;
        chk("mic_commit_play", 32'(scr_m), 32'd2);
        chk("play_load", 32'(left_m), 32'd5);

        // countdown during the wipe; timeout request waits for the wipe to end
        for (int i = 4; i >= 0; i--) begin
            frame_m(1);
            chk("play_count", 32'(left_m), 32'(i));
        end
        frame_m(5);
        chk("timeout_held_in_wipe", 32'(scr_m), 32'd2);
        chk("left_saturates", 32'(left_m), 32'd0);
        frame_m(1);
        chk("play_wipe_off", 32'(wipe_m), 32'd0);
        frame_m(1);
        chk("timeout_over", 32'(scr_m), 32'd3);

        // GAME_OVER -> TITLE, then reset in the middle of that wipe
        frame_m(11);
        chk("over_wipe_off", 32'(wipe_m), 32'd0);
        press_m();
        frame_m(1);
        chk("over_to_title", 32'(scr_m), 32'd0);
        pix = 13'd50;
        @(negedge clk);
        chk("title_wipe_prev", 32'(oled_m), 32'(C_O));
        reset = 1'b1;
        @(negedge clk);
        chk("midwipe_rst_screen", 32'(scr_m), 32'd0);
        chk("midwipe_rst_wipe", 32'(wipe_m), 32'd0);
        chk("midwipe_rst_oled", 32'(oled_m), 32'd0);
        reset = 1'b0;

        // decode boundaries
        pix = 13'd6143;
        #1;
        chk("x_last", 32'(x_m), 32'd95);
        chk("y_last", 32'(y_m), 32'd63);
        @(negedge clk);
        chk("oled_last", 32'(oled_m), 32'(C_T));
        pix = 13'd6200;
        #1;
        chk("x_oob", 32'(x_m), 32'd0);
        chk("y_oob", 32'(y_m), 32'd0);
        @(negedge clk);
        chk("oled_oob_black", 32'(oled_m), 32'd0);

        // one-frame wipe and game_lost with a button in PLAY
        press_f();
        frame_f(1);
        chk("fast_mic", 32'(scr_f), 32'd1);
        chk("fast_wipe_on", 32'(wipe_f), 32'd1);
        frame_f(1);
        chk("fast_wipe_one_frame", 32'(wipe_f), 32'd0);
        press_f();
        frame_f(1);
        chk("fast_play", 32'(scr_f), 32'd2);
        frame_f(1);
        chk("fast_left4", 32'(left_f), 32'd4);
        lost_f = 1'b1;
        btn_f = 1'b1;
        @(negedge clk);
        lost_f = 1'b0;
        btn_f = 1'b0;
        @(negedge clk);
        chk("lost_waits_frame", 32'(scr_f), 32'd2);
        frame_f(1);
        chk("lost_over", 32'(scr_f), 32'd3);
        pix = 13'd101;
        #1;
        chk("fast_x", 32'(x_f), 32'd5);
        chk("fast_y", 32'(y_f), 32'd1);
        @(negedge clk);
        chk("fast_oled_over", 32'(oled_f), 32'(C_O));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
